// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: a multi-digit BCD up/down counter that advances once per
// rising edge of a slow, asynchronous TICK_IN square wave. START/STOP/CLEAR
// drive a small IDLE/RUN/HOLD controller, and TC_PULSE flags each wrap-around.
module tick_bcd_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK_IN,
  input  logic                  RST_N,
  input  logic                  TICK_IN,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CLEAR,
  input  logic                  DOWN,
  output logic [4*DIGITS-1:0]   BCD_OUT,
  output logic                  RUNNING,
  output logic                  TC_PULSE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_en;
  logic                   count_en;
  logic [4*DIGITS-1:0]    bcd_q;
  logic [4*DIGITS-1:0]    bcd_nxt;
  logic                   wrap;
  logic                   carry;
  logic [3:0]             digit_cur;
  logic [3:0]             digit_nxt;
  logic                   running_q;
  logic                   tc_q;

  // Synchronize TICK_IN and keep one flop of history for rising-edge detect.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], TICK_IN};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_en  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign count_en = tick_en && (state_q == RUN) && !CLEAR;

  // Controller state register.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state: CLEAR wins, STOP only matters in RUN, START only outside RUN.
  always_comb begin
    state_nxt = state_q;
    if (CLEAR) begin
      state_nxt = IDLE;
    end else if (STOP && (state_q == RUN)) begin
      state_nxt = HOLD;
    end else if (START && (state_q != RUN)) begin
      state_nxt = RUN;
    end
  end

  // Ripple the decimal carry/borrow through the digits; a carry out of the top
  // digit means the whole counter wrapped.
  always_comb begin
    bcd_nxt   = bcd_q;
    carry     = 1'b1;
    digit_cur = 4'd0;
    digit_nxt = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_cur = bcd_q[4*i +: 4];
      digit_nxt = digit_cur;
      if (carry) begin
        if (!DOWN) begin
          if (digit_cur >= 4'd9) begin
            digit_nxt = 4'd0;
          end else begin
            digit_nxt = digit_cur + 4'd1;
            carry     = 1'b0;
          end
        end else begin
          if (digit_cur == 4'd0) begin
            digit_nxt = 4'd9;
          end else if (digit_cur > 4'd9) begin
            digit_nxt = 4'd9;
            carry     = 1'b0;
          end else begin
            digit_nxt = digit_cur - 4'd1;
            carry     = 1'b0;
          end
        end
      end
      bcd_nxt[4*i +: 4] = digit_nxt;
    end
    wrap = carry;
  end

  // Count register and wrap pulse; CLEAR discards any coincident tick.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
    end else if (CLEAR) begin
      bcd_q <= '0;
      tc_q  <= 1'b0;
    end else if (count_en) begin
      bcd_q <= bcd_nxt;
      tc_q  <= wrap;
    end else begin
      tc_q  <= 1'b0;
    end
  end

  // RUNNING mirrors the registered state so it is glitch-free.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      running_q <= 1'b0;
    end else begin
      running_q <= (state_nxt == RUN);
    end
  end

  assign BCD_OUT  = bcd_q;
  assign RUNNING  = running_q;
  assign TC_PULSE = tc_q;

endmodule

// File: doc/tick_bcd_counter.md
TICK_BCD_COUNTER -- requirements
Module: tick_bcd_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4 (legal 1..8), setting the number of BCD digits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2 (legal 2..3), setting the synchronizer depth on TICK_IN.
REQ-003 The block SHALL have port CLK_IN, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port TICK_IN, input, 1 bit: the slow square wave from the frequency divider, treated as asynchronous.
REQ-006 The block SHALL have port START, input, 1 bit: synchronous to CLK_IN, acted on in any cycle where it is sampled high.
REQ-007 The block SHALL have port STOP, input, 1 bit: synchronous to CLK_IN, acted on in any cycle where it is sampled high.
REQ-008 The block SHALL have port CLEAR, input, 1 bit: synchronous to CLK_IN, acted on in any cycle where it is sampled high.
REQ-009 The block SHALL have port DOWN, input, 1 bit: count direction, 0 = up, 1 = down, sampled on each counting tick.
REQ-010 The block SHALL have port BCD_OUT, output, 4*DIGITS bits: registered count; digit 0 (least significant) is in bits [3:0].
REQ-011 The block SHALL have port RUNNING, output, 1 bit: registered, high only while in state RUN.
REQ-012 The block SHALL have port TC_PULSE, output, 1 bit: registered, one-cycle pulse on each wrap-around.

Function
REQ-013 TICK_IN SHALL pass through SYNC_STAGES flip-flops, then one edge-history flip-flop; tick_en = last sync stage high AND history low.
REQ-014 With SYNC_STAGES=2, the clock edge at which BCD_OUT updates SHALL be the 3rd CLK_IN rising edge, counting the first edge that samples TICK_IN high as the 1st.
REQ-015 The falling edge of TICK_IN SHALL produce no tick; TICK_IN high for N cycles SHALL produce exactly one tick_en.
REQ-016 The FSM SHALL have states IDLE, RUN and HOLD.
REQ-017 FSM transition IDLE->RUN SHALL occur on START.
REQ-018 FSM transition RUN->HOLD SHALL occur on STOP.
REQ-019 FSM transition HOLD->RUN SHALL occur on START.
REQ-020 Any state SHALL go to IDLE on CLEAR, with BCD_OUT set to 0.
REQ-021 Command priority SHALL be CLEAR > STOP > START; START in RUN and STOP in IDLE or HOLD SHALL have no effect.
REQ-022 The count SHALL change only when tick_en is high and the current (pre-edge) state is RUN.
REQ-023 A tick in the same cycle as STOP SHALL still count; a tick in the same cycle as START from IDLE or HOLD SHALL not count.
REQ-024 A tick in the same cycle as CLEAR SHALL be discarded; the result SHALL be 0 and no TC_PULSE.
REQ-025 Up counting SHALL be decimal per digit: a digit at 9 becomes 0 and carries into the next digit.
REQ-026 Down counting SHALL be decimal per digit: a digit at 0 becomes 9 and borrows from the next digit.
REQ-027 All-nines +1 SHALL wrap to all-zeros; all-zeros -1 SHALL wrap to all-nines.
REQ-028 On every wrap, TC_PULSE SHALL be high for exactly one cycle, in the same cycle that BCD_OUT first shows the wrapped value.
REQ-029 DOWN SHALL be able to change between ticks; each tick SHALL use the DOWN value sampled in its own cycle.
REQ-030 Each BCD digit SHALL never hold a value above 9.
REQ-031 HOLD SHALL retain BCD_OUT unchanged indefinitely.

Reset
REQ-032 While RST_N is low, the block SHALL hold: FSM = IDLE, BCD_OUT = 0, RUNNING = 0, TC_PULSE = 0, all sync and history flops = 0.
REQ-033 Reset assertion SHALL take effect immediately, without waiting for a clock edge, including mid-count or mid-TC_PULSE.
REQ-034 After RST_N is released, the block SHALL stay in IDLE until START.
REQ-035 If TICK_IN is high at reset release, it SHALL produce one tick_en, which is ignored because the state is IDLE.

Verification
REQ-036 Scenario: reset release, START, then 12 TICK_IN rising edges with DOWN=0 -> BCD_OUT = 0x0012, RUNNING = 1, TC_PULSE never high.
REQ-037 Scenario: preload to 0x9998 by ticking, then 2 ticks with DOWN=0 -> BCD_OUT shows 0x9999 then 0x0000, with TC_PULSE high for exactly the one cycle in which 0x0000 first appears.
REQ-038 Scenario: from 0x0000 in RUN, one tick with DOWN=1 -> BCD_OUT = 0x9999 and one TC_PULSE; then DOWN=0 and one tick -> 0x0000 and a second TC_PULSE.
REQ-039 Scenario: count 0x0005 in RUN, STOP coincident with tick_en -> 0x0006 and HOLD; 3 further ticks -> 0x0006 unchanged; START plus 1 tick -> 0x0007.
REQ-040 Scenario: CLEAR asserted together with START and STOP while a tick is pending at 0x0042 -> 0x0000, IDLE, RUNNING = 0, no TC_PULSE.
REQ-041 Scenario: RST_N pulled low between clock edges while at 0x0137 in RUN -> outputs 0 immediately; TICK_IN held high for 50 cycles after release, then START, and no new edge -> BCD_OUT stays 0x0000.
